icache_fetch_unit: RTL and testbench
====================================

ICACHE_FETCH_UNIT -- requirements
Module: icache_fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 8, instruction queue entries (power of 2, >=4).
REQ-002 SHALL have parameter RESET_PC, default 32'h1ECEB000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  redirect request from backend.
REQ-006 SHALL have port flush_pc  input  32  redirect target, word aligned.
REQ-007 SHALL have port icache_addr  output  32  fetch address to icache ufp_addr.
REQ-008 SHALL have port icache_valid  output  1  fetch request valid to icache input_valid.
REQ-009 SHALL have port icache_flush  output  1  pipeline flush to icache.
REQ-010 SHALL have port icache_read_stall  input  1  icache pipeline frozen.
REQ-011 SHALL have port icache_resp  input  1  icache response valid.
REQ-012 SHALL have port icache_rdata  input  32  returned instruction.
REQ-013 SHALL have port icache_raddr  input  32  address of returned instruction.
REQ-014 SHALL have port deq  input  1  decode pops head entry.
REQ-015 SHALL have port inst_valid  output  1  queue non-empty.
REQ-016 SHALL have port inst  output  32  head instruction.
REQ-017 SHALL have port inst_pc  output  32  head instruction address.
REQ-018 SHALL have port count  output  $clog2(DEPTH)+1  queue occupancy.

Function
REQ-019 SHALL hold fetch_pc register; icache_addr = fetch_pc combinationally.
REQ-020 SHALL assert icache_valid when !flush and (count + inflight) < DEPTH.
REQ-021 SHALL treat request accepted when icache_valid && !icache_read_stall; on accept fetch_pc <= fetch_pc + 4.
REQ-022 SHALL keep fetch_pc and icache_addr stable while icache_read_stall is high.
REQ-023 SHALL treat response accepted only when icache_resp && !icache_read_stall (stalled icache holds resp high; held cycles not counted).
REQ-024 SHALL track inflight (0..2, 2-bit): +1 on accepted request, -1 on accepted response, both same cycle = unchanged.
REQ-025 SHALL enqueue {icache_raddr, icache_rdata} at tail on accepted response when icache_raddr equals expected_pc, then expected_pc += 4.
REQ-026 SHALL drop an accepted response whose icache_raddr != expected_pc (still decrement inflight).
REQ-027 SHALL provide hit latency: request accepted cycle N, unstalled -> entry visible on inst_valid at cycle N+3.
REQ-028 SHALL drive inst/inst_pc from head entry combinationally; inst_valid = (count != 0).
REQ-029 SHALL pop head on deq && inst_valid; deq when empty ignored with no state change.
REQ-030 SHALL support simultaneous enqueue and pop: count unchanged, both pointers advance.
REQ-031 SHALL never overflow: credit rule REQ-020 guarantees free slot for every in-flight response; count saturates at DEPTH.
REQ-032 SHALL wrap head/tail pointers modulo DEPTH.
REQ-033 SHALL on flush: icache_flush = flush combinationally; next cycle queue empty, inflight = 0, fetch_pc = expected_pc = flush_pc; no request issued in the flush cycle.
REQ-034 SHALL give flush priority over simultaneous deq, enqueue and request accept.

Reset
REQ-035 SHALL on rst: fetch_pc = expected_pc = RESET_PC, head = tail = 0, count = 0, inflight = 0.
REQ-036 SHALL in reset cycle drive icache_valid = 0, inst_valid = 0, icache_flush = 0; rst mid-operation discards all entries identically.
REQ-037 SHALL issue first request (addr RESET_PC) in first cycle after rst deasserts.

Verification
REQ-038 SHALL cover: reset, all-hit icache, no deq -> addrs 1ECEB000..1ECEB01C issued, count reaches 8, icache_valid drops, inflight 0.
REQ-039 SHALL cover: full queue, deq 1 cycle -> exactly one new request 1ECEB020, entry lands 3 cycles later, count returns to 8.
REQ-040 SHALL cover: icache_read_stall high 20 cycles with icache_resp high -> one enqueue only, icache_addr constant throughout.
REQ-041 SHALL cover: flush with flush_pc 32'h00001000 while 2 in flight and 5 queued -> next cycle count 0, inst_valid 0, first new request addr 00001000.
REQ-042 SHALL cover: flush and deq same cycle on non-empty queue -> queue empty, no double pop, head pointer equals tail.
REQ-043 SHALL cover: injected response with raddr 1ECEB008 when expecting 1ECEB004 -> dropped, count unchanged, inflight decremented.

Source files
------------

// File: rtl/icache_fetch_unit.sv
// ============================================================================
//  Module      : icache_fetch_unit
//  Description : Instruction fetch front end. Issues sequential fetch
//                requests to a pipelined icache under a credit rule that
//                reserves a queue slot for every in-flight request, filters
//                returned instructions against the expected PC, and buffers
//                them in a circular instruction queue for decode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_fetch_unit #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h1ECEB000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [31:0]                flush_pc,
  output logic [31:0]                icache_addr,
  output logic                       icache_valid,
  output logic                       icache_flush,
  input  logic                       icache_read_stall,
  input  logic                       icache_resp,
  input  logic [31:0]                icache_rdata,
  input  logic [31:0]                icache_raddr,
  input  logic                       deq,
  output logic                       inst_valid,
  output logic [31:0]                inst,
  output logic [31:0]                inst_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]   C_CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] C_FULL_COUNT   = CNT_W'(DEPTH);

  // Architectural state
  logic [31:0]      fetch_pc_q,    fetch_pc_d;
  logic [31:0]      expected_pc_q, expected_pc_d;
  logic [1:0]       inflight_q,    inflight_d;
  logic [PTR_W-1:0] head_q,        head_d;
  logic [PTR_W-1:0] tail_q,        tail_d;
  logic [CNT_W-1:0] count_q,       count_d;

  // Queue storage (no reset needed: validity is tracked by count_q)
  logic [31:0] inst_mem_q [DEPTH];
  logic [31:0] pc_mem_q   [DEPTH];

  // Handshake qualifiers
  logic             has_credit;
  logic [CNT_W:0]   occupancy;
  logic             req_fire;
  logic             resp_fire;
  logic             resp_match;
  logic             do_pop;
  logic             do_enq;

  // Occupancy counts both buffered and in-flight instructions, so every
  // issued request is guaranteed a free slot when its response returns.
  assign occupancy  = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
  assign has_credit = (occupancy < C_CREDIT_LIMIT);

  assign icache_addr  = fetch_pc_q;
  assign icache_valid = !rst && !flush && has_credit;
  assign icache_flush = flush && !rst;

  // A stalled icache holds its response high; only the unstalled cycle counts.
  assign req_fire   = icache_valid && !icache_read_stall;
  assign resp_fire  = icache_resp && !icache_read_stall && !flush && !rst;
  assign resp_match = resp_fire && (icache_raddr == expected_pc_q);
  assign do_pop     = deq && (count_q != '0) && !flush && !rst;
  assign do_enq     = resp_match && ((count_q != C_FULL_COUNT) || do_pop);

  assign inst_valid = !rst && (count_q != '0);
  assign inst       = inst_mem_q[head_q];
  assign inst_pc    = pc_mem_q[head_q];
  assign count      = count_q;

  // Next-state computation; a redirect overrides every other update.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    expected_pc_d = expected_pc_q;
    inflight_d    = inflight_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;

    if (flush) begin
      fetch_pc_d    = flush_pc;
      expected_pc_d = flush_pc;
      inflight_d    = 2'd0;
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end

      if (do_enq) begin
        expected_pc_d = expected_pc_q + 32'd4;
        tail_d        = tail_q + PTR_W'(1);
      end

      if (do_pop) begin
        head_d = head_q + PTR_W'(1);
      end

      unique case ({do_enq, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase

      // Dropped (mismatched) responses still retire their in-flight credit.
      unique case ({req_fire, resp_fire})
        2'b10:   inflight_d = inflight_q + 2'd1;
        2'b01:   inflight_d = (inflight_q != 2'd0) ? inflight_q - 2'd1 : 2'd0;
        default: inflight_d = inflight_q;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      expected_pc_q <= RESET_PC;
      inflight_q    <= 2'd0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      expected_pc_q <= expected_pc_d;
      inflight_q    <= inflight_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  // Queue storage write at the tail on an accepted, in-order response.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_enq) begin
      inst_mem_q[tail_q] <= icache_rdata;
      pc_mem_q[tail_q]   <= icache_raddr;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icache_fetch_unit.sv
// ============================================================================
//  Module      : tb_icache_fetch_unit
//  Description : Self-checking bench for icache_fetch_unit. A two-stage
//                pipelined icache model feeds the DUT; a queue-based
//                reference model predicts queue contents, credit and fetch
//                address; a monitor compares the DUT every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_fetch_unit;

  localparam int          DEPTH    = 8;
  localparam logic [31:0] RESET_PC = 32'h1ECEB000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic [31:0] icache_addr;
  logic        icache_valid;
  logic        icache_flush;
  logic        icache_read_stall = 1'b0;
  logic        icache_resp;
  logic [31:0] icache_rdata;
  logic [31:0] icache_raddr;
  logic        deq = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  icache_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .flush_pc          (flush_pc),
    .icache_addr       (icache_addr),
    .icache_valid      (icache_valid),
    .icache_flush      (icache_flush),
    .icache_read_stall (icache_read_stall),
    .icache_resp       (icache_resp),
    .icache_rdata      (icache_rdata),
    .icache_raddr      (icache_raddr),
    .deq               (deq),
    .inst_valid        (inst_valid),
    .inst              (inst),
    .inst_pc           (inst_pc),
    .count             (count)
  );

  always #5 clk = ~clk;

  // ---------------- icache model: two-stage pipeline, freezes on stall -----
  logic        s1_v = 1'b0, s2_v = 1'b0;
  logic [31:0] s1_a = 32'h0, s2_a = 32'h0;
  logic [31:0] salt = 32'h0;
  logic        corrupt = 1'b0;

  always @(posedge clk) begin
    if (rst || flush) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else if (!icache_read_stall) begin
      s2_v <= s1_v;
      s2_a <= s1_a;
      s1_v <= icache_valid;
      s1_a <= icache_addr;
    end
  end

  assign icache_resp  = s2_v;
  assign icache_raddr = corrupt ? s2_a + 32'd4 : s2_a;
  assign icache_rdata = {s2_a[15:0], s2_a[31:16]} ^ salt;

  // ---------------- reference model / scoreboard ---------------------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  ent_t        sb[$];
  int          m_infl  = 0;
  logic [31:0] m_fetch = RESET_PC;
  logic [31:0] m_exp   = RESET_PC;

  function automatic logic exp_req_valid();
    return !rst && !flush && ((sb.size() + m_infl) < DEPTH);
  endfunction

  // Predictor: applies the fetch/queue rules for the cycle just observed.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      m_infl  <= 0;
      m_fetch <= RESET_PC;
      m_exp   <= RESET_PC;
    end else if (flush) begin
      sb.delete();
      m_infl  <= 0;
      m_fetch <= flush_pc;
      m_exp   <= flush_pc;
    end else begin
      m_infl <= m_infl
              + ((exp_req_valid() && !icache_read_stall) ? 1 : 0)
              - ((icache_resp && !icache_read_stall && m_infl > 0) ? 1 : 0);
      if (exp_req_valid() && !icache_read_stall)
        m_fetch <= m_fetch + 32'd4;
      if (deq && sb.size() > 0)
        void'(sb.pop_front());
      if (icache_resp && !icache_read_stall && icache_raddr == m_exp) begin
        sb.push_back('{pc: icache_raddr, data: icache_rdata});
        m_exp <= m_exp + 32'd4;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against the model every cycle.
  always @(posedge clk) begin
    #2;
    chk("count", 32'(count), 32'(sb.size()));
    chk("inst_valid", 32'(inst_valid), 32'(!rst && sb.size() != 0));
    chk("icache_valid", 32'(icache_valid), 32'(exp_req_valid()));
    chk("icache_flush", 32'(icache_flush), 32'(flush && !rst));
    chk("icache_addr", icache_addr, m_fetch);
    if (!rst && sb.size() != 0) begin
      chk("inst_pc", inst_pc, sb[0].pc);
      chk("inst", inst, sb[0].data);
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    salt = $urandom();

    // Reset, with flush held high to confirm it is masked during reset.
    rst = 1'b1; flush = 1'b1; flush_pc = 32'h0000_0040;
    repeat (3) step();
    @(negedge clk);
    chk("rst_icache_valid", 32'(icache_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_icache_flush", 32'(icache_flush), 32'd0);

    // First request right after reset, then fill the queue with no deq.
    step(); rst = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("first_req_valid", 32'(icache_valid), 32'd1);
    chk("first_req_addr", icache_addr, RESET_PC);
    repeat (12) step();
    @(negedge clk);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_valid_drop", 32'(icache_valid), 32'd0);
    chk("fill_next_addr", icache_addr, 32'h1ECEB020);

    // One deq on a full queue frees exactly one credit.
    step(); deq = 1'b1;
    step(); deq = 1'b0;
    @(negedge clk);
    chk("refill_req_valid", 32'(icache_valid), 32'd1);
    chk("refill_req_addr", icache_addr, 32'h1ECEB020);
    step();
    @(negedge clk);
    chk("refill_one_only", 32'(icache_valid), 32'd0);
    step();
    @(negedge clk);
    chk("refill_count_pre", 32'(count), 32'd7);
    step();
    @(negedge clk);
    chk("refill_count", 32'(count), 32'd8);

    // Redirect, then freeze the icache for 20 cycles with a response held.
    step(); flush = 1'b1; flush_pc = 32'h0000_2000;
    @(negedge clk);
    chk("flush_out", 32'(icache_flush), 32'd1);
    chk("flush_no_req", 32'(icache_valid), 32'd0);
    step(); flush = 1'b0;
    @(negedge clk);
    chk("redirect_addr", icache_addr, 32'h0000_2000);
    step();
    step(); icache_read_stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i != 0) step();
      @(negedge clk);
      chk("stall_addr", icache_addr, 32'h0000_2008);
      chk("stall_count", 32'(count), 32'd0);
    end
    step(); icache_read_stall = 1'b0;
    step();
    @(negedge clk);
    chk("stall_one_enq", 32'(count), 32'd1);
    chk("stall_enq_pc", inst_pc, 32'h0000_2000);

    // Flush with two requests in flight and five entries queued.
    step(); flush = 1'b1; flush_pc = 32'h0000_3000;
    step(); flush = 1'b0;
    repeat (7) step();
    flush = 1'b1; flush_pc = 32'h0000_1000;
    @(negedge clk);
    chk("preflush_count", 32'(count), 32'd5);
    step(); flush = 1'b0;
    @(negedge clk);
    chk("postflush_count", 32'(count), 32'd0);
    chk("postflush_inst_valid", 32'(inst_valid), 32'd0);
    chk("postflush_addr", icache_addr, 32'h0000_1000);

    // Flush and deq together on a non-empty queue.
    repeat (6) step();
    flush = 1'b1; deq = 1'b1; flush_pc = 32'h0000_4000;
    @(negedge clk);
    chk("fd_nonempty", 32'(inst_valid), 32'd1);
    step(); flush = 1'b0; deq = 1'b0;
    @(negedge clk);
    chk("fd_count", 32'(count), 32'd0);
    chk("fd_head_eq_tail", 32'(dut.head_q == dut.tail_q), 32'd1);

    // Out-of-order response injection is dropped.
    step(); flush = 1'b1; flush_pc = RESET_PC;
    step(); flush = 1'b0;
    step();
    step();
    step(); corrupt = 1'b1;
    @(negedge clk);
    chk("inj_raddr", icache_raddr, 32'h1ECEB008);
    step(); corrupt = 1'b0;
    @(negedge clk);
    chk("inj_dropped", 32'(count), 32'd1);
    chk("inj_head", inst_pc, RESET_PC);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      step();
      rst               = ($urandom_range(299) == 0);
      flush             = ($urandom_range(49) == 0);
      flush_pc          = $urandom() & 32'hFFFF_FFFC;
      deq               = ($urandom_range(1) == 0);
      icache_read_stall = ($urandom_range(4) == 0);
      corrupt           = ($urandom_range(99) == 0);
    end
    step();
    rst = 1'b0; flush = 1'b0; deq = 1'b0; icache_read_stall = 1'b0; corrupt = 1'b0;
    repeat (5) step();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
